// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_ctrl_pkg                                                              |
// | Opcodes, ALU-op codes, state encoding and control word for the multicycle  |
// | MIPS controller.                                                           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL: is_known_op = 1'b1;
      default:                                 is_known_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_outputs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl_outputs                                                            |
// | Combinational state-to-control-word decoder (optional MC_CTRL_MEM_WAIT_EN).|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mc_ctrl_outputs
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic       mem_ready_i,
`endif
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = ALUOP_ADD;
`ifdef MC_CTRL_MEM_WAIT_EN
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
`else
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
`endif
      end
      S_DECODE: ctrl_o.alu_src_b = 2'b11;
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 2'b01;
      end
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = 2'b01;
        ctrl_o.branch_eq = (opcode_i == OP_BEQ);
        ctrl_o.branch_ne = (opcode_i == OP_BNE);
      end
      S_IEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        case (opcode_i)
          OP_ANDI: ctrl_o.alu_op = ALUOP_AND;
          OP_ORI:  ctrl_o.alu_op = ALUOP_OR;
          OP_SLTI: ctrl_o.alu_op = ALUOP_SLT;
          default: ctrl_o.alu_op = ALUOP_ADD;
        endcase
      end
      S_IWB: ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = 2'b10;
      end
      S_JAL: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = 2'b10;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 2'b10;
        ctrl_o.mem_to_reg = 2'b10;
      end
      default: ctrl_o = '0;
    endcase
  end

  // Only output that looks at the opcode outside the execute states.
  assign illegal_o = (state_i == S_DECODE) && !is_known_op(opcode_i);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_controller                                                      |
// | Multicycle MIPS control FSM with retired-instruction counter.              |
// | Optional memory-wait handshake: define MC_CTRL_MEM_WAIT_EN.                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               branch_eq,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_t            ctrl;
  logic             illegal;
  logic             mem_go;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_go           = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
          OP_J:                              state_d = S_JUMP;
          OP_JAL:                            state_d = S_JAL;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_go ? S_FETCH : S_MEMWR;
      S_EXEC_R: state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // An instruction retires when control returns to FETCH, except when DECODE rejected it.
  always_comb begin
    count_d = count_q;
    if ((state_q != S_FETCH) && (state_d == S_FETCH) && !illegal)
      count_d = count_q + CNT_W'(1);
  end

  mc_ctrl_outputs u_outputs (
    .state_i     (state_q),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready_i (mem_ready),
`endif
    .opcode_i    (opcode),
    .ctrl_o      (ctrl),
    .illegal_o   (illegal)
  );

  assign pc_write    = ctrl.pc_write;
  assign branch_eq   = ctrl.branch_eq;
  assign branch_ne   = ctrl.branch_ne;
  assign iord        = ctrl.iord;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign ir_write    = ctrl.ir_write;
  assign reg_write   = ctrl.reg_write;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ALUOP_W'(ctrl.alu_op);
  assign pc_src      = ctrl.pc_src;
  assign illegal_op  = illegal;
  assign state_o     = STATE_W'(state_q);
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_controller                                                   |
// | Directed scoreboard bench for multicycle_controller (default build).       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

  localparam logic [3:0] T_FETCH = 4'd0,  T_DECODE = 4'd1, T_MEMADR = 4'd2,
                         T_MEMRD = 4'd3,  T_MEMWB  = 4'd4, T_MEMWR  = 4'd5,
                         T_EXECR = 4'd6,  T_ALUWB  = 4'd7, T_BRANCH = 4'd8,
                         T_IEXEC = 4'd9,  T_IWB    = 4'd10, T_JUMP  = 4'd11,
                         T_JAL   = 4'd12;

  typedef struct packed {
    logic       pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
  } cw_t;

  typedef struct {
    string      tag;
    logic [3:0] st;
    cw_t        cw;
    logic       ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = 6'b100011;
  logic        mem_ready = 1'b1;
  logic        pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic        alu_src_a, illegal_op;
  logic [2:0]  alu_op;
  logic [3:0]  state_o;
  logic [31:0] instr_count;

  cw_t   obs_cw;
  exp_t  sb[$];
  int    n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] exp_count = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .state_o(state_o),
    .instr_count(instr_count)
  );

  assign obs_cw = {pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write,
                   reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference control word for each state, written from the opcode/state tables.
  function automatic cw_t exp_cw(input logic [3:0] st, input logic [5:0] op);
    cw_t c = '0;
    case (st)
      T_FETCH:  begin c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01; end
      T_DECODE: c.alu_src_b = 2'b11;
      T_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      T_MEMRD:  begin c.iord = 1; c.mem_read = 1; end
      T_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      T_MEMWR:  begin c.iord = 1; c.mem_write = 1; end
      T_EXECR:  begin c.alu_src_a = 1; c.alu_op = 3'b010; end
      T_ALUWB:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
      T_BRANCH: begin
        c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_src = 2'b01;
        c.branch_eq = (op == 6'b000100); c.branch_ne = (op == 6'b000101);
      end
      T_IEXEC: begin
        c.alu_src_a = 1; c.alu_src_b = 2'b10;
        c.alu_op = (op == 6'b001100) ? 3'b011 : (op == 6'b001101) ? 3'b100 :
                   (op == 6'b001010) ? 3'b101 : 3'b000;
      end
      T_IWB:  c.reg_write = 1;
      T_JUMP: begin c.pc_write = 1; c.pc_src = 2'b10; end
      T_JAL:  begin
        c.pc_write = 1; c.pc_src = 2'b10; c.reg_write = 1;
        c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Drive one opcode, queue the expected per-cycle trace, then drain it cycle by cycle.
  task automatic run_instr(input logic [5:0] op, input string name);
    logic [3:0] p[$];
    logic       ill = 1'b0;
    exp_t       e;
    opcode = op;
    p.push_back(T_FETCH);
    p.push_back(T_DECODE);
    case (op)
      6'b100011: begin p.push_back(T_MEMADR); p.push_back(T_MEMRD); p.push_back(T_MEMWB); end
      6'b101011: begin p.push_back(T_MEMADR); p.push_back(T_MEMWR); end
      6'b000000: begin p.push_back(T_EXECR); p.push_back(T_ALUWB); end
      6'b000100, 6'b000101: p.push_back(T_BRANCH);
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin p.push_back(T_IEXEC); p.push_back(T_IWB); end
      6'b000010: p.push_back(T_JUMP);
      6'b000011: p.push_back(T_JAL);
      default:   ill = 1'b1;
    endcase
    foreach (p[i])
      sb.push_back('{tag: $sformatf("%s/c%0d", name, i + 1), st: p[i],
                     cw: exp_cw(p[i], op), ill: (ill && p[i] == T_DECODE)});
    if (!ill) exp_count++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "/state"}, 32'(state_o), 32'(e.st));
      check({e.tag, "/ctrl"}, 32'(obs_cw), 32'(e.cw));
      check({e.tag, "/illegal"}, 32'(illegal_op), 32'(e.ill));
      @(posedge clk);
      #1;
    end
    check({name, "/count"}, instr_count, exp_count);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset/state", 32'(state_o), 32'(T_FETCH));
    check("reset/ctrl", 32'(obs_cw), 32'(exp_cw(T_FETCH, opcode)));
    check("reset/count", instr_count, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    run_instr(6'b100011, "lw");
    run_instr(6'b101011, "sw");
    run_instr(6'b000100, "beq");
    run_instr(6'b000101, "bne");
    run_instr(6'b000011, "jal");
    run_instr(6'b001101, "ori");
    run_instr(6'b111111, "illegal");
    run_instr(6'b000000, "rtype");
    run_instr(6'b001000, "addi");
    run_instr(6'b001100, "andi");
    run_instr(6'b001010, "slti");
    run_instr(6'b000010, "j");

    // Abort a store mid-MEMWR with an asynchronous reset away from the clock edge.
    opcode = 6'b101011;
    repeat (3) @(posedge clk);
    #1;
    check("abort/in_memwr", 32'(state_o), 32'(T_MEMWR));
    check("abort/mem_write_before", 32'(mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort/mem_write", 32'(mem_write), 32'd0);
    check("abort/state", 32'(state_o), 32'(T_FETCH));
    check("abort/count", instr_count, 32'd0);
    check("abort/ctrl", 32'(obs_cw), 32'(exp_cw(T_FETCH, opcode)));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_count = 0;
    run_instr(6'b100011, "lw_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
